// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : DMI request/response types, op and status codes, sequencer state.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned DMI_ABITS = 7;

    typedef struct packed {
        logic [DMI_ABITS-1:0] addr;
        logic [31:0]          data;
        logic [1:0]           op;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DTM_NOP   = 2'd0;
    localparam logic [1:0] DTM_READ  = 2'd1;
    localparam logic [1:0] DTM_WRITE = 2'd2;

    localparam logic [1:0] DMINoError  = 2'd0;
    localparam logic [1:0] DMIOpFailed = 2'd2;
    localparam logic [1:0] DMIBusy     = 2'd3;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_REQ  = 2'd1,
        SEQ_RESP = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/dmi_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dmi_req_sequencer
// Brief    : Bridges TAP level strobes to DMI valid/ready channels and keeps the
//            sticky dmistat error. Optional macro DMI_SEQ_TIMEOUT_EN adds abort.
// Revision : 1.0 - initial release
// ============================================================================
module dmi_req_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned ABITS          = DMI_ABITS
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       TAP_READ_I,
    input  logic       TAP_WRITE_I,
    input  dmi_req_t   TAP_DMI_I,
    output dmi_req_t   TAP_DMI_O,
    output logic       TAP_DONE_O,
    input  logic       HARD_RESET_I,
    input  logic       CLEAR_ERROR_I,
    output logic [1:0] DMI_ERROR_O,
    output logic       DMI_REQ_VALID_O,
    input  logic       DMI_REQ_READY_I,
    output dmi_req_t   DMI_REQ_O,
    input  logic       DMI_RESP_VALID_I,
    output logic       DMI_RESP_READY_O,
    input  dmi_resp_t  DMI_RESP_I
);

    seq_state_e       state_q, state_d;
    dmi_req_t         req_q, req_d;
    dmi_req_t         tap_dmi_q, tap_dmi_d;
    logic [1:0]       error_q, error_d;
    logic             w_set_err;
    logic [1:0]       w_set_val;
    logic             w_timeout;
    logic [ABITS-1:0] w_addr;
    logic [1:0]       w_unused_op;

    assign w_addr      = TAP_DMI_I.addr;
    // The TAP's op field is implied by which strobe is raised.
    assign w_unused_op = TAP_DMI_I.op;

`ifdef DMI_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK_I) begin
        if (RST_I || HARD_RESET_I) begin
            cnt_q <= '0;
        end else if (state_q == SEQ_REQ || state_q == SEQ_RESP) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign w_timeout = (state_q == SEQ_REQ || state_q == SEQ_RESP) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        tap_dmi_d = tap_dmi_q;
        error_d   = error_q;
        w_set_err = 1'b0;
        w_set_val = DMINoError;

        case (state_q)
            SEQ_IDLE: begin
                if (TAP_WRITE_I || TAP_READ_I) begin
                    req_d.addr = w_addr;
                    if (TAP_WRITE_I) begin
                        req_d.data = TAP_DMI_I.data;
                        req_d.op   = DTM_WRITE;
                    end else begin
                        req_d.data = 32'h0;
                        req_d.op   = DTM_READ;
                    end
                    // A pending sticky error short-circuits the bus access.
                    if (error_q != DMINoError) begin
                        tap_dmi_d = '{addr: w_addr, data: 32'h0, op: error_q};
                        state_d   = SEQ_DONE;
                    end else begin
                        state_d = SEQ_REQ;
                    end
                end
            end
            SEQ_REQ: begin
                if (DMI_REQ_READY_I) begin
                    state_d = SEQ_RESP;
                end else if (w_timeout) begin
                    tap_dmi_d = '{addr: req_q.addr, data: 32'h0, op: DMIBusy};
                    w_set_err = 1'b1;
                    w_set_val = DMIBusy;
                    state_d   = SEQ_DONE;
                end
            end
            SEQ_RESP: begin
                if (DMI_RESP_VALID_I) begin
                    tap_dmi_d = '{addr: req_q.addr, data: DMI_RESP_I.data,
                                  op: DMI_RESP_I.resp};
                    if (DMI_RESP_I.resp == DMIOpFailed || DMI_RESP_I.resp == DMIBusy) begin
                        w_set_err = 1'b1;
                        w_set_val = DMI_RESP_I.resp;
                    end
                    state_d = SEQ_DONE;
                end else if (w_timeout) begin
                    tap_dmi_d = '{addr: req_q.addr, data: 32'h0, op: DMIBusy};
                    w_set_err = 1'b1;
                    w_set_val = DMIBusy;
                    state_d   = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                if (!TAP_WRITE_I && !TAP_READ_I) begin
                    state_d = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        if (CLEAR_ERROR_I) begin
            error_d = DMINoError;
        end
        if (w_set_err) begin
            error_d = w_set_val;
        end

        if (HARD_RESET_I) begin
            state_d   = SEQ_IDLE;
            req_d     = '{addr: '0, data: '0, op: DTM_NOP};
            tap_dmi_d = '0;
            error_d   = DMINoError;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= SEQ_IDLE;
            req_q     <= '{addr: '0, data: '0, op: DTM_NOP};
            tap_dmi_q <= '0;
            error_q   <= DMINoError;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            tap_dmi_q <= tap_dmi_d;
            error_q   <= error_d;
        end
    end

    assign DMI_REQ_VALID_O  = (state_q == SEQ_REQ);
    assign DMI_RESP_READY_O = (state_q == SEQ_RESP);
    assign TAP_DONE_O       = (state_q == SEQ_DONE);
    assign DMI_REQ_O        = req_q;
    assign TAP_DMI_O        = tap_dmi_q;
    assign DMI_ERROR_O      = error_q;

endmodule : dmi_req_sequencer
`default_nettype wire

// File: tb/tb_dmi_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_req_sequencer
// Brief    : Directed self-checking bench for dmi_req_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmi_req_sequencer;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        TAP_READ_I = 1'b0;
    logic        TAP_WRITE_I = 1'b0;
    logic [40:0] TAP_DMI_I = '0;
    logic [40:0] TAP_DMI_O;
    logic        TAP_DONE_O;
    logic        HARD_RESET_I = 1'b0;
    logic        CLEAR_ERROR_I = 1'b0;
    logic [1:0]  DMI_ERROR_O;
    logic        DMI_REQ_VALID_O;
    logic        DMI_REQ_READY_I = 1'b0;
    logic [40:0] DMI_REQ_O;
    logic        DMI_RESP_VALID_I = 1'b0;
    logic        DMI_RESP_READY_O;
    logic [33:0] DMI_RESP_I = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    dmi_req_sequencer #(
        .TIMEOUT_CYCLES(20),
        .ABITS         (7)
    ) dut (
        .CLK_I           (CLK_I),
        .RST_I           (RST_I),
        .TAP_READ_I      (TAP_READ_I),
        .TAP_WRITE_I     (TAP_WRITE_I),
        .TAP_DMI_I       (TAP_DMI_I),
        .TAP_DMI_O       (TAP_DMI_O),
        .TAP_DONE_O      (TAP_DONE_O),
        .HARD_RESET_I    (HARD_RESET_I),
        .CLEAR_ERROR_I   (CLEAR_ERROR_I),
        .DMI_ERROR_O     (DMI_ERROR_O),
        .DMI_REQ_VALID_O (DMI_REQ_VALID_O),
        .DMI_REQ_READY_I (DMI_REQ_READY_I),
        .DMI_REQ_O       (DMI_REQ_O),
        .DMI_RESP_VALID_I(DMI_RESP_VALID_I),
        .DMI_RESP_READY_O(DMI_RESP_READY_O),
        .DMI_RESP_I      (DMI_RESP_I)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic test_reset();
        RST_I = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({TAP_DONE_O, DMI_REQ_VALID_O, DMI_RESP_READY_O} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000", {TAP_DONE_O, DMI_REQ_VALID_O, DMI_RESP_READY_O});
        end
        n_cmp++;
        if ({TAP_DMI_O, DMI_REQ_O, DMI_ERROR_O} !== 84'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {TAP_DMI_O, DMI_REQ_O, DMI_ERROR_O});
        end
        RST_I = 1'b0;
        tick();
    endtask

    task automatic test_write();
        int done_at;
        done_at = -1;
        TAP_DMI_I        = {7'h10, 32'hDEADBEEF, 2'h0};
        DMI_REQ_READY_I  = 1'b1;
        DMI_RESP_VALID_I = 1'b1;
        DMI_RESP_I       = {32'h0, 2'd0};
        TAP_WRITE_I      = 1'b1;
        tick();
        n_cmp++;
        if (DMI_REQ_VALID_O !== 1'b1 || DMI_REQ_O !== {7'h10, 32'hDEADBEEF, 2'd2}) begin
            n_fail++;
            $display("FAIL wr_req: got v=%b %h expected v=1 %h", DMI_REQ_VALID_O, DMI_REQ_O, {7'h10, 32'hDEADBEEF, 2'd2});
        end
        for (int c = 2; c <= 6; c++) begin
            if (TAP_DONE_O === 1'b1 && done_at < 0) done_at = c - 1;
            if (done_at < 0) tick();
        end
        n_cmp++;
        if (done_at !== 3) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d expected 3", done_at);
        end
        n_cmp++;
        if (TAP_DMI_O !== {7'h10, 32'h0, 2'd0} || DMI_ERROR_O !== 2'd0) begin
            n_fail++;
            $display("FAIL wr_result: got %h err=%0d expected %h err=0", TAP_DMI_O, DMI_ERROR_O, {7'h10, 32'h0, 2'd0});
        end
        TAP_WRITE_I      = 1'b0;
        DMI_REQ_READY_I  = 1'b0;
        DMI_RESP_VALID_I = 1'b0;
        tick();
        n_cmp++;
        if (TAP_DONE_O !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_release: got %b expected 0", TAP_DONE_O);
        end
    endtask

    task automatic test_read_delayed();
        int n_valid;
        n_valid = 0;
        TAP_DMI_I   = {7'h11, 32'hFFFFFFFF, 2'h0};
        TAP_READ_I  = 1'b1;
        tick();
        for (int i = 0; i < 8 && DMI_REQ_VALID_O === 1'b1; i++) begin
            n_valid++;
            if (n_valid == 6) DMI_REQ_READY_I = 1'b1;
            n_cmp++;
            if (DMI_REQ_O !== {7'h11, 32'h0, 2'd1}) begin
                n_fail++;
                $display("FAIL rd_req_stable: got %h expected %h", DMI_REQ_O, {7'h11, 32'h0, 2'd1});
            end
            tick();
        end
        n_cmp++;
        if (n_valid !== 6 || DMI_RESP_READY_O !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_valid_len: got %0d rready=%b expected 6 rready=1", n_valid, DMI_RESP_READY_O);
        end
        DMI_REQ_READY_I  = 1'b0;
        DMI_RESP_VALID_I = 1'b1;
        DMI_RESP_I       = {32'h00000ABC, 2'd0};
        tick();
        n_cmp++;
        if (TAP_DONE_O !== 1'b1 || TAP_DMI_O !== {7'h11, 32'h00000ABC, 2'd0}) begin
            n_fail++;
            $display("FAIL rd_result: got done=%b %h expected done=1 %h", TAP_DONE_O, TAP_DMI_O, {7'h11, 32'h00000ABC, 2'd0});
        end
        TAP_READ_I       = 1'b0;
        DMI_RESP_VALID_I = 1'b0;
        tick();
    endtask

    task automatic test_error();
        TAP_DMI_I        = {7'h12, 32'h0, 2'h0};
        DMI_REQ_READY_I  = 1'b1;
        DMI_RESP_VALID_I = 1'b1;
        DMI_RESP_I       = {32'h00000055, 2'd2};
        TAP_READ_I       = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (TAP_DONE_O !== 1'b1 || TAP_DMI_O !== {7'h12, 32'h55, 2'd2} || DMI_ERROR_O !== 2'd2) begin
            n_fail++;
            $display("FAIL err_set: got done=%b %h err=%0d expected done=1 %h err=2", TAP_DONE_O, TAP_DMI_O, DMI_ERROR_O, {7'h12, 32'h55, 2'd2});
        end
        TAP_READ_I       = 1'b0;
        DMI_REQ_READY_I  = 1'b0;
        DMI_RESP_VALID_I = 1'b0;
        tick();
        TAP_DMI_I   = {7'h13, 32'h00001234, 2'h0};
        TAP_WRITE_I = 1'b1;
        tick();
        n_cmp++;
        if (TAP_DONE_O !== 1'b1 || DMI_REQ_VALID_O !== 1'b0 || TAP_DMI_O !== {7'h13, 32'h0, 2'd2}) begin
            n_fail++;
            $display("FAIL err_skip: got done=%b v=%b %h expected done=1 v=0 %h", TAP_DONE_O, DMI_REQ_VALID_O, TAP_DMI_O, {7'h13, 32'h0, 2'd2});
        end
        TAP_WRITE_I   = 1'b0;
        tick();
        CLEAR_ERROR_I = 1'b1;
        tick();
        CLEAR_ERROR_I = 1'b0;
        n_cmp++;
        if (DMI_ERROR_O !== 2'd0) begin
            n_fail++;
            $display("FAIL err_clear: got %0d expected 0", DMI_ERROR_O);
        end
        DMI_REQ_READY_I  = 1'b1;
        DMI_RESP_VALID_I = 1'b1;
        DMI_RESP_I       = {32'h0, 2'd0};
        TAP_WRITE_I      = 1'b1;
        tick();
        n_cmp++;
        if (DMI_REQ_VALID_O !== 1'b1 || DMI_REQ_O !== {7'h13, 32'h00001234, 2'd2}) begin
            n_fail++;
            $display("FAIL err_after_clear: got v=%b %h expected v=1 %h", DMI_REQ_VALID_O, DMI_REQ_O, {7'h13, 32'h00001234, 2'd2});
        end
        tick(); tick();
        TAP_WRITE_I = 1'b0;
        tick();
        // Clear held through a busy response: the set must win.
        DMI_RESP_I    = {32'h0, 2'd3};
        CLEAR_ERROR_I = 1'b1;
        TAP_READ_I    = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (TAP_DONE_O !== 1'b1 || DMI_ERROR_O !== 2'd3) begin
            n_fail++;
            $display("FAIL err_set_wins: got done=%b err=%0d expected done=1 err=3", TAP_DONE_O, DMI_ERROR_O);
        end
        TAP_READ_I       = 1'b0;
        DMI_REQ_READY_I  = 1'b0;
        DMI_RESP_VALID_I = 1'b0;
        tick();
        CLEAR_ERROR_I = 1'b0;
        n_cmp++;
        if (DMI_ERROR_O !== 2'd0) begin
            n_fail++;
            $display("FAIL err_clear2: got %0d expected 0", DMI_ERROR_O);
        end
    endtask

    task automatic test_hard_reset();
        int bad;
        bad = 0;
        TAP_DMI_I       = {7'h20, 32'h0, 2'h0};
        DMI_REQ_READY_I = 1'b1;
        TAP_READ_I      = 1'b1;
        tick(); tick();
        n_cmp++;
        if (DMI_RESP_READY_O !== 1'b1) begin
            n_fail++;
            $display("FAIL hr_in_resp: got %b expected 1", DMI_RESP_READY_O);
        end
        DMI_REQ_READY_I = 1'b0;
        HARD_RESET_I    = 1'b1;
        TAP_READ_I      = 1'b0;
        tick();
        HARD_RESET_I = 1'b0;
        n_cmp++;
        if ({TAP_DONE_O, DMI_REQ_VALID_O, DMI_RESP_READY_O} !== 3'b000) begin
            n_fail++;
            $display("FAIL hr_abort: got %b expected 000", {TAP_DONE_O, DMI_REQ_VALID_O, DMI_RESP_READY_O});
        end
        DMI_RESP_VALID_I = 1'b1;
        DMI_RESP_I       = {32'hBAD0BAD0, 2'd2};
        for (int i = 0; i < 3; i++) begin
            tick();
            if (TAP_DONE_O !== 1'b0 || DMI_RESP_READY_O !== 1'b0 || DMI_ERROR_O !== 2'd0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hr_late_resp: got %0d bad cycles expected 0", bad);
        end
        DMI_RESP_VALID_I = 1'b0;
    endtask

    task automatic test_both_strobes();
        TAP_DMI_I        = {7'h14, 32'hCAFEF00D, 2'h0};
        DMI_REQ_READY_I  = 1'b1;
        DMI_RESP_VALID_I = 1'b1;
        DMI_RESP_I       = {32'h0, 2'd0};
        TAP_WRITE_I      = 1'b1;
        TAP_READ_I       = 1'b1;
        tick();
        n_cmp++;
        if (DMI_REQ_O !== {7'h14, 32'hCAFEF00D, 2'd2}) begin
            n_fail++;
            $display("FAIL both_op: got %h expected %h", DMI_REQ_O, {7'h14, 32'hCAFEF00D, 2'd2});
        end
        tick(); tick();
        TAP_WRITE_I = 1'b0;
        tick();
        n_cmp++;
        if (TAP_DONE_O !== 1'b1 || TAP_DMI_O !== {7'h14, 32'h0, 2'd0}) begin
            n_fail++;
            $display("FAIL both_hold: got done=%b %h expected done=1 %h", TAP_DONE_O, TAP_DMI_O, {7'h14, 32'h0, 2'd0});
        end
        TAP_READ_I       = 1'b0;
        DMI_REQ_READY_I  = 1'b0;
        DMI_RESP_VALID_I = 1'b0;
        tick();
        n_cmp++;
        if (TAP_DONE_O !== 1'b0) begin
            n_fail++;
            $display("FAIL both_release: got %b expected 0", TAP_DONE_O);
        end
    endtask

    task automatic test_strobe_drop();
        TAP_DMI_I  = {7'h15, 32'h0, 2'h0};
        TAP_READ_I = 1'b1;
        tick();
        TAP_READ_I = 1'b0;
        tick();
        n_cmp++;
        if (DMI_REQ_VALID_O !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_valid_held: got %b expected 1", DMI_REQ_VALID_O);
        end
        DMI_REQ_READY_I = 1'b1;
        tick();
        DMI_REQ_READY_I  = 1'b0;
        DMI_RESP_VALID_I = 1'b1;
        DMI_RESP_I       = {32'h0000F00D, 2'd0};
        tick();
        DMI_RESP_VALID_I = 1'b0;
        n_cmp++;
        if (TAP_DONE_O !== 1'b1 || TAP_DMI_O !== {7'h15, 32'h0000F00D, 2'd0}) begin
            n_fail++;
            $display("FAIL drop_done: got done=%b %h expected done=1 %h", TAP_DONE_O, TAP_DMI_O, {7'h15, 32'h0000F00D, 2'd0});
        end
        tick();
        n_cmp++;
        if (TAP_DONE_O !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_fallthrough: got %b expected 0", TAP_DONE_O);
        end
    endtask

    task automatic test_timeout();
        int n_valid;
        n_valid = 0;
        TAP_DMI_I  = {7'h16, 32'h0, 2'h0};
        TAP_READ_I = 1'b1;
        tick();
        for (int i = 0; i < 30 && DMI_REQ_VALID_O === 1'b1; i++) begin
            n_valid++;
            tick();
        end
`ifdef DMI_SEQ_TIMEOUT_EN
        n_cmp++;
        if (n_valid !== 20 || TAP_DONE_O !== 1'b1 || DMI_ERROR_O !== 2'd3 || TAP_DMI_O !== {7'h16, 32'h0, 2'd3}) begin
            n_fail++;
            $display("FAIL timeout_abort: got n=%0d done=%b err=%0d %h expected n=20 done=1 err=3 %h", n_valid, TAP_DONE_O, DMI_ERROR_O, TAP_DMI_O, {7'h16, 32'h0, 2'd3});
        end
        TAP_READ_I    = 1'b0;
        CLEAR_ERROR_I = 1'b1;
        tick();
        CLEAR_ERROR_I = 1'b0;
`else
        n_cmp++;
        if (n_valid !== 30 || TAP_DONE_O !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_wait: got n=%0d done=%b expected n=30 done=0", n_valid, TAP_DONE_O);
        end
        TAP_READ_I   = 1'b0;
        HARD_RESET_I = 1'b1;
        tick();
        HARD_RESET_I = 1'b0;
`endif
        n_cmp++;
        if (DMI_REQ_VALID_O !== 1'b0 || DMI_ERROR_O !== 2'd0) begin
            n_fail++;
            $display("FAIL timeout_recover: got v=%b err=%0d expected v=0 err=0", DMI_REQ_VALID_O, DMI_ERROR_O);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_delayed();
        test_error();
        test_hard_reset();
        test_both_strobes();
        test_strobe_drop();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dmi_req_sequencer
`default_nettype wire

// File: doc/dmi_req_sequencer.md
Name: dmi_req_sequencer

Overview:
- Sequences DMI transactions between the UART TAP (level read/write strobes, DONE handshake) and the debug module's valid/ready DMI request/response channels.
- Builds the request, waits for the response, and returns the response repacked in dmi_req_t format.
- Keeps the sticky 2-bit DMI error status that the TAP reports in dtmcs.dmistat.
- Sits between the TAP and the debug module inside the UART debug transport.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles allowed in REQ+RESP before abort (only with DMI_SEQ_TIMEOUT_EN).
- ABITS, 7, DMI address width; must equal the dmi_req_t address field width.

Ports:
- CLK_I  in  1  clock; all logic on rising edge.
- RST_I  in  1  synchronous, active-high reset.
- TAP_READ_I  in  1  level read request from TAP; held until TAP_DONE_O is seen.
- TAP_WRITE_I  in  1  level write request from TAP; held until TAP_DONE_O is seen.
- TAP_DMI_I  in  41  dmi_req_t {addr[40:34], data[33:2], op[1:0]}; sampled in IDLE.
- TAP_DMI_O  out  41  {captured addr, resp.data, resp.resp}.
- TAP_DONE_O  out  1  transaction finished.
- HARD_RESET_I  in  1  dtmcs.dmihardreset; aborts and clears.
- CLEAR_ERROR_I  in  1  dtmcs.dmireset; clears sticky error.
- DMI_ERROR_O  out  2  sticky status: 0 ok, 2 failed, 3 busy.
- DMI_REQ_VALID_O  out  1  request valid.
- DMI_REQ_READY_I  in  1  debug module accepts request.
- DMI_REQ_O  out  41  dmi_req_t to debug module.
- DMI_RESP_VALID_I  in  1  response valid.
- DMI_RESP_READY_O  out  1  sequencer accepts response.
- DMI_RESP_I  in  34  dmi_resp_t {data[33:2], resp[1:0]}.

Behaviour:
- Reset values: all outputs 0; state IDLE; error 0; captured request 0.
- IDLE, with TAP_WRITE_I or TAP_READ_I high:
  - Latch the request: addr=TAP_DMI_I[40:34]. Write: data=TAP_DMI_I[33:2], op=2. Read: data=0, op=1.
  - Write has priority if both strobes are high.
  - If DMI_ERROR_O!=0, skip the bus: load TAP_DMI_O={addr, 32'h0, error}, go to DONE next cycle.
  - Otherwise go to REQ.
- REQ:
  - DMI_REQ_VALID_O=1; DMI_REQ_O held stable.
  - On VALID&&READY, go to RESP next cycle. Earliest READY gives 1 cycle in REQ.
- RESP:
  - DMI_RESP_READY_O=1.
  - On RESP_VALID, capture TAP_DMI_O={addr, DMI_RESP_I[33:2], DMI_RESP_I[1:0]} and go to DONE.
  - resp==2 or 3 sets the sticky error to that value; resp==0 leaves it unchanged.
- DONE:
  - TAP_DONE_O=1 and TAP_DMI_O stable while either TAP strobe is high.
  - Return to IDLE when both strobes are low.
  - Minimum IDLE-to-DONE latency: 3 cycles with READY and RESP_VALID both asserted immediately.
- Error clear:
  - CLEAR_ERROR_I clears the error next cycle, in any state.
  - If it coincides with an error being set, the set wins.
- Hard reset:
  - HARD_RESET_I acts like RST_I except it is not a port reset: next state IDLE, VALID/READY/DONE low next cycle, error 0.
  - A request accepted in the same cycle is dropped.
  - A response arriving later, outside RESP, is ignored (RESP_READY=0).
- Strobe drop: if the TAP strobe drops in REQ/RESP (TAP timeout), the bus transaction completes anyway; DONE then falls straight through to IDLE.
- Valid/ready rules: VALID_O never deasserts before READY is seen (except on reset or hard reset). DMI_RESP_READY_O is high only in RESP.

Optional Feature:
- Macro: DMI_SEQ_TIMEOUT_EN.
- With the macro:
  - A counter runs in REQ and RESP and clears elsewhere.
  - On reaching TIMEOUT_CYCLES, the block sets error=3, drops VALID/READY, loads TAP_DMI_O={addr, 0, 3} and goes to DONE.
- Without the macro: no counter; the block waits indefinitely.

Decomposition:
- uart_pkg holds:
  - dmi_req_t and dmi_resp_t;
  - op constants DTM_NOP=0, DTM_READ=1, DTM_WRITE=2;
  - status constants DMINoError=0, DMIOpFailed=2, DMIBusy=3;
  - the sequencer state enum.
- No sub-module is needed. The timeout counter stays inline under the macro.

Test Plan:
- Write: TAP_WRITE_I, TAP_DMI_I={7'h10, 32'hDEADBEEF, 2'h0}, immediate ready and resp=0 → DMI_REQ_O={7'h10, DEADBEEF, 2}, DONE at cycle 3, error 0.
- Read: addr 7'h11, READY delayed 5 cycles, resp data 32'h00000ABC → VALID held 6 cycles; TAP_DMI_O={11, ABC, 0}.
- resp=2 on read → DMI_ERROR_O=2. The next write gets DONE without VALID and TAP_DMI_O[1:0]=2. CLEAR_ERROR_I → 0, and the following access uses the bus.
- HARD_RESET_I pulsed in RESP → IDLE next cycle, DONE never asserted, and a later RESP_VALID is ignored.
- Both strobes high → op=2; DONE held until both strobes are low.
- With DMI_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, READY never asserted → DONE after 20 cycles, error=3; without the macro the block stays in REQ.
